// File: rtl/roulette_round_sequencer.sv
// Roulette round sequencer: buffers chip-tagged bets, launches the wheel on the
// spin key, then streams stored bets to the payout engine and clears the round.
module roulette_round_sequencer #(
   parameter int          MAX_BETS     = 12,
   parameter logic [31:0] SPIN_TIMEOUT = 32'd500_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [5:0] key_opcode,
   input  logic [2:0] chip_color,
   input  logic       wheel_done,
   input  logic       pay_ready,
   output logic [3:0] bet_count,
   output logic       spin_start,
   output logic [7:0] bet_out,
   output logic       bet_out_valid,
   output logic       round_done,
   output logic       reject,
   output logic       spin_abort,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_BET   = 2'd0,
      ST_SPIN  = 2'd1,
      ST_PAY   = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam logic [5:0] OP_SPIN = 6'b111110;
   localparam logic [5:0] OP_NOP  = 6'b111111;
   localparam logic [3:0] MAX_CNT = 4'(MAX_BETS);

   state_t      cur_state;
   logic [7:0]  bet_buf [MAX_BETS];
   logic [3:0]  idx;
   logic [31:0] spin_timer;
   logic        pay_last;

   assign state    = cur_state;
   assign pay_last = (idx == bet_count - 4'd1);

   // Payout handshake: an entry transfers in every cycle where bet_out_valid
   // and pay_ready are both high; bet_out is held unchanged otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state     <= ST_BET;
         bet_count     <= 4'd0;
         idx           <= 4'd0;
         spin_timer    <= 32'd0;
         bet_out       <= 8'd0;
         bet_out_valid <= 1'b0;
         spin_start    <= 1'b0;
         round_done    <= 1'b0;
         reject        <= 1'b0;
         spin_abort    <= 1'b0;
         for (int i = 0; i < MAX_BETS; i++) bet_buf[i] <= 8'd0;
      end else begin
         spin_start <= 1'b0;
         round_done <= 1'b0;
         reject     <= 1'b0;
         spin_abort <= 1'b0;
         case (cur_state)
            ST_BET: begin
               if (key_valid) begin
                  if (key_opcode == OP_SPIN) begin
                     if (bet_count != 4'd0) begin
                        cur_state  <= ST_SPIN;
                        spin_start <= 1'b1;
                        spin_timer <= 32'd0;
                     end else begin
                        reject <= 1'b1;
                     end
                  end else if (key_opcode != OP_NOP) begin
                     if (chip_color != 3'd0 && bet_count < MAX_CNT) begin
                        bet_buf[bet_count] <= {chip_color[1:0], key_opcode};
                        bet_count          <= bet_count + 4'd1;
                     end else begin
                        reject <= 1'b1;
                     end
                  end
               end
            end
            ST_SPIN: begin
               // wheel_done is checked first so it wins over a coincident expiry
               if (wheel_done) begin
                  cur_state     <= ST_PAY;
                  idx           <= 4'd0;
                  bet_out       <= bet_buf[0];
                  bet_out_valid <= 1'b1;
               end else if (spin_timer == SPIN_TIMEOUT - 32'd1) begin
                  cur_state  <= ST_BET;
                  spin_abort <= 1'b1;
               end else begin
                  spin_timer <= spin_timer + 32'd1;
               end
            end
            ST_PAY: begin
               if (pay_ready) begin
                  if (pay_last) begin
                     cur_state     <= ST_CLEAR;
                     round_done    <= 1'b1;
                     bet_out_valid <= 1'b0;
                     bet_out       <= 8'd0;
                  end else begin
                     idx     <= idx + 4'd1;
                     bet_out <= bet_buf[idx + 4'd1];
                  end
               end
            end
            ST_CLEAR: begin
               cur_state <= ST_BET;
               bet_count <= 4'd0;
               for (int i = 0; i < MAX_BETS; i++) bet_buf[i] <= 8'd0;
            end
            default: cur_state <= ST_BET;
         endcase
      end
   end

endmodule

// File: tb/tb_roulette_round_sequencer.sv
// Directed bench for roulette_round_sequencer: a vector table for the basic
// round plus hand-written sequences for full buffer, timeout, stalls and reset.
module tb_roulette_round_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [5:0] key_opcode;
   logic [2:0] chip_color;
   logic       wheel_done;
   logic       pay_ready;
   logic [3:0] bet_count;
   logic       spin_start;
   logic [7:0] bet_out;
   logic       bet_out_valid;
   logic       round_done;
   logic       reject;
   logic       spin_abort;
   logic [1:0] state;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int m_cnt = 0;

   roulette_round_sequencer #(.MAX_BETS(12), .SPIN_TIMEOUT(32'd16)) dut (
      .clock(clock), .reset(reset), .key_valid(key_valid), .key_opcode(key_opcode),
      .chip_color(chip_color), .wheel_done(wheel_done), .pay_ready(pay_ready),
      .bet_count(bet_count), .spin_start(spin_start), .bet_out(bet_out),
      .bet_out_valid(bet_out_valid), .round_done(round_done), .reject(reject),
      .spin_abort(spin_abort), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       kv;
      logic [5:0] op;
      logic [2:0] chip;
      logic       wd;
      logic       pr;
      logic [1:0] e_st;
      logic [3:0] e_cnt;
      logic       e_rej;
      logic       e_ss;
      logic       e_bov;
      logic [7:0] e_bo;
      logic       e_rd;
      logic       e_ab;
   } vec_t;

   vec_t vecs[16];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bet or no-op key press in BET, checked against a small buffer model.
   task automatic press(input logic [5:0] op, input logic [2:0] chip);
      logic exp_rej;
      exp_rej = 1'b0;
      if (op < 6'd62) begin
         if (chip != 3'd0 && m_cnt < 12) begin
            exp_q.push_back({chip[1:0], op});
            m_cnt++;
         end else begin
            exp_rej = 1'b1;
         end
      end
      key_valid = 1'b1; key_opcode = op; chip_color = chip;
      tick();
      key_valid = 1'b0;
      chk($sformatf("press_%0d_reject", op), reject, exp_rej);
      chk($sformatf("press_%0d_count", op), bet_count, m_cnt);
   endtask

   task automatic spin_and_wheel();
      key_valid = 1'b1; key_opcode = 6'b111110; chip_color = 3'd0;
      tick();
      key_valid = 1'b0;
      chk("spin_state", state, 2'd1);
      chk("spin_start", spin_start, 1'b1);
      wheel_done = 1'b1;
      tick();
      wheel_done = 1'b0;
      chk("pay_state", state, 2'd2);
      chk("pay_valid", bet_out_valid, 1'b1);
   endtask

   task automatic pay_all(input int n_exp);
      int paid;
      paid = 0;
      pay_ready = 1'b1;
      for (int c = 0; c < 40 && bet_out_valid; c++) begin
         if (exp_q.size() == 0) begin
            chk("pay_extra_entry", 32'd1, 32'd0);
            break;
         end
         chk($sformatf("pay_entry_%0d", paid), bet_out, exp_q.pop_front());
         paid++;
         tick();
      end
      pay_ready = 1'b0;
      chk("pay_handshakes", paid, n_exp);
      chk("clear_state", state, 2'd3);
      chk("clear_round_done", round_done, 1'b1);
      tick();
      chk("after_clear_state", state, 2'd0);
      chk("after_clear_count", bet_count, 4'd0);
      chk("after_clear_round_done", round_done, 1'b0);
      m_cnt = 0;
   endtask

   initial begin
      int spin_cycles;
      int extra_ss;
      reset = 1'b1; key_valid = 1'b0; key_opcode = 6'd0; chip_color = 3'd0;
      wheel_done = 1'b0; pay_ready = 1'b0;

      //          rst kv op  chip wd pr | st cnt rej ss bov bo    rd ab
      vecs[0]  = '{1, 0, 0,  0,   0, 0,   0, 0,  0,  0, 0,  8'h00, 0, 0};
      vecs[1]  = '{0, 1, 5,  5,   0, 0,   0, 1,  0,  0, 0,  8'h00, 0, 0};
      vecs[2]  = '{0, 1, 17, 5,   0, 0,   0, 2,  0,  0, 0,  8'h00, 0, 0};
      vecs[3]  = '{0, 1, 40, 5,   0, 0,   0, 3,  0,  0, 0,  8'h00, 0, 0};
      vecs[4]  = '{0, 1, 63, 5,   0, 0,   0, 3,  0,  0, 0,  8'h00, 0, 0};
      vecs[5]  = '{0, 1, 7,  0,   0, 0,   0, 3,  1,  0, 0,  8'h00, 0, 0};
      vecs[6]  = '{0, 1, 62, 0,   0, 0,   1, 3,  0,  1, 0,  8'h00, 0, 0};
      vecs[7]  = '{0, 0, 0,  0,   0, 0,   1, 3,  0,  0, 0,  8'h00, 0, 0};
      vecs[8]  = '{0, 1, 9,  5,   0, 0,   1, 3,  0,  0, 0,  8'h00, 0, 0};
      vecs[9]  = '{0, 0, 0,  0,   1, 0,   2, 3,  0,  0, 1,  8'h45, 0, 0};
      vecs[10] = '{0, 0, 0,  0,   0, 1,   2, 3,  0,  0, 1,  8'h51, 0, 0};
      vecs[11] = '{0, 0, 0,  0,   0, 1,   2, 3,  0,  0, 1,  8'h68, 0, 0};
      vecs[12] = '{0, 0, 0,  0,   0, 1,   3, 3,  0,  0, 0,  8'h00, 1, 0};
      vecs[13] = '{0, 0, 0,  0,   0, 0,   0, 0,  0,  0, 0,  8'h00, 0, 0};
      vecs[14] = '{0, 1, 62, 0,   0, 0,   0, 0,  1,  0, 0,  8'h00, 0, 0};
      vecs[15] = '{0, 0, 0,  0,   1, 0,   0, 0,  0,  0, 0,  8'h00, 0, 0};

      for (int v = 0; v < 16; v++) begin
         reset = vecs[v].rst; key_valid = vecs[v].kv; key_opcode = vecs[v].op;
         chip_color = vecs[v].chip; wheel_done = vecs[v].wd; pay_ready = vecs[v].pr;
         tick();
         chk($sformatf("vec%0d_state", v), state, vecs[v].e_st);
         chk($sformatf("vec%0d_count", v), bet_count, vecs[v].e_cnt);
         chk($sformatf("vec%0d_reject", v), reject, vecs[v].e_rej);
         chk($sformatf("vec%0d_spin_start", v), spin_start, vecs[v].e_ss);
         chk($sformatf("vec%0d_valid", v), bet_out_valid, vecs[v].e_bov);
         chk($sformatf("vec%0d_bet_out", v), bet_out, vecs[v].e_bo);
         chk($sformatf("vec%0d_round_done", v), round_done, vecs[v].e_rd);
         chk($sformatf("vec%0d_abort", v), spin_abort, vecs[v].e_ab);
      end
      key_valid = 1'b0; wheel_done = 1'b0; pay_ready = 1'b0;

      // 13 bets: the last one is refused with the buffer full
      for (int i = 0; i < 13; i++) press(6'(i + 1), 3'b011);
      spin_and_wheel();
      pay_all(12);

      // Timeout: two bets, no wheel_done, abort after 16 SPIN cycles
      press(6'd1, 3'd1);
      press(6'd2, 3'd1);
      key_valid = 1'b1; key_opcode = 6'b111110;
      tick();
      key_valid = 1'b0;
      chk("to_spin_state", state, 2'd1);
      spin_cycles = 1;
      extra_ss = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (state == 2'd1) begin
            spin_cycles++;
            if (spin_start) extra_ss++;
         end else begin
            break;
         end
      end
      chk("to_spin_cycles", spin_cycles, 16);
      chk("to_extra_spin_start", extra_ss, 0);
      chk("to_abort", spin_abort, 1'b1);
      chk("to_state_bet", state, 2'd0);
      chk("to_count_kept", bet_count, 4'd2);
      tick();
      chk("to_abort_one_cycle", spin_abort, 1'b0);
      spin_and_wheel();
      pay_all(2);

      // Stalled payout with key presses during PAY
      press(6'd10, 3'd2);
      press(6'd11, 3'd2);
      press(6'd12, 3'd2);
      spin_and_wheel();
      chk("stall_first", bet_out, 8'h8A);
      pay_ready = 1'b0; tick(); chk("stall_p0a", bet_out, 8'h8A);
      pay_ready = 1'b1; tick(); chk("stall_p1a", bet_out, 8'h8B);
      pay_ready = 1'b0; key_valid = 1'b1; key_opcode = 6'd3; chip_color = 3'd1;
      tick();
      key_valid = 1'b0;
      chk("stall_p0b", bet_out, 8'h8B);
      chk("pay_key_no_reject", reject, 1'b0);
      chk("pay_key_no_count", bet_count, 4'd3);
      pay_ready = 1'b0; tick(); chk("stall_p0c", bet_out, 8'h8B);
      chk("stall_valid_held", bet_out_valid, 1'b1);
      pay_ready = 1'b1; tick(); chk("stall_p1b", bet_out, 8'h8C);
      tick();
      pay_ready = 1'b0;
      chk("stall_clear_state", state, 2'd3);
      chk("stall_round_done", round_done, 1'b1);
      tick();
      chk("stall_done_count", bet_count, 4'd0);
      m_cnt = 0;
      exp_q.delete();

      // Reset in the middle of PAY after one handshake
      press(6'd20, 3'd4);
      press(6'd21, 3'd4);
      spin_and_wheel();
      pay_ready = 1'b1; tick();
      chk("mid_pay_second", bet_out, 8'h15);
      pay_ready = 1'b0; reset = 1'b1; tick();
      chk("rst_state", state, 2'd0);
      chk("rst_count", bet_count, 4'd0);
      chk("rst_valid", bet_out_valid, 1'b0);
      chk("rst_bet_out", bet_out, 8'd0);
      chk("rst_round_done", round_done, 1'b0);
      reset = 1'b0; tick();
      chk("post_rst_round_done", round_done, 1'b0);
      chk("post_rst_spin_start", spin_start, 1'b0);
      chk("post_rst_state", state, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/roulette_round_sequencer.md
# roulette_round_sequencer

Sequences one roulette round around the bet buffer. It collects keyboard bets tagged with the Arduino chip colour into a 12-entry buffer and launches the wheel on the spin key. It waits for the wheel to finish, then streams every stored bet to the payout engine over a valid/ready handshake and clears for the next round. It sits between the PS/2 decode path (`keyboardToBet`) and the regfile payout logic, and replaces the free-running bet counter and the case-decoded bet latches.

## Interface
Parameters:
- `MAX_BETS`, default 12: buffer depth.
- `SPIN_TIMEOUT`, default 32'd500_000_000: cycles allowed in SPIN before abort.

Ports:
- `clock`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `key_valid`  in  1: one-cycle strobe; `key_opcode` is valid in that cycle.
- `key_opcode`  in  6: decoded bet opcode. 6'b111110 = spin; 6'b111111 = no-op.
- `chip_color`  in  3: Arduino chip sensor. 3'b000 = no chip.
- `wheel_done`  in  1: level or pulse from the wheel/motor side.
- `pay_ready`  in  1: payout engine accepts `bet_out` this cycle.
- `bet_count`  out  4: number of stored bets, 0..MAX_BETS.
- `spin_start`  out  1: one-cycle pulse that starts the wheel.
- `bet_out`  out  8: current payout entry, `{chip_color[1:0], opcode}`.
- `bet_out_valid`  out  1: `bet_out` is valid.
- `round_done`  out  1: one-cycle pulse at the end of a round.
- `reject`  out  1: one-cycle pulse when a key press is refused.
- `spin_abort`  out  1: one-cycle pulse on spin timeout.
- `state`  out  2: BET=0, SPIN=1, PAY=2, CLEAR=3.

## Operation
States and transitions:
- **BET** (reset state)
  - Bet accept: `key_valid` & opcode < 6'b111110 & `chip_color` != 0 & `bet_count` < MAX_BETS. Writes `{chip_color[1:0], key_opcode}` into `buf[bet_count]` and increments `bet_count`.
  - Bet refuse: a `key_valid` with a bet opcode and no chip, or with the buffer full. Pulses `reject`; buffer and count are unchanged.
  - Opcode 6'b111111 is ignored silently, with no `reject`.
  - Spin with `bet_count` ≥ 1 goes to SPIN. Spin with `bet_count` = 0 pulses `reject` and stays in BET.
- **SPIN**
  - `spin_start` pulses on the first cycle in SPIN, then the timeout counter runs.
  - `wheel_done`=1 goes to PAY with read index = 0.
  - If the counter reaches SPIN_TIMEOUT−1 without `wheel_done`, pulse `spin_abort` and return to BET. Bets are retained.
- **PAY**
  - `bet_out_valid`=1 and `bet_out` = `buf[idx]`.
  - On `pay_ready`, idx increments. When idx = `bet_count`−1 and `pay_ready`=1, go to CLEAR.
  - `bet_out` is held stable while `pay_ready`=0.
- **CLEAR**: one cycle. `bet_count`←0, all buffer entries ←0, `round_done` pulses, then go to BET.

Input handling rules:
- `key_valid` outside BET is ignored, with no `reject`.
- `wheel_done` outside SPIN is ignored.

Reset values:
- `state`=BET, `bet_count`=0, all buffer entries 0.
- `bet_out`=0, and all strobes/valids 0.

Widths:
- idx: 4 bits.
- Timeout counter: 32 bits, no wrap.
- `bet_count` saturates at MAX_BETS.

## Timing
- An accepted bet is visible on `bet_count` one cycle after the `key_valid` cycle.
- Spin accepted in cycle N: `state`=SPIN and `spin_start`=1 in cycle N+1. `spin_start` is never high for more than one cycle.
- `wheel_done` in cycle M: `state`=PAY and `bet_out_valid`=1 from cycle M+1.
- Minimum payout throughput is one entry per cycle while `pay_ready` is held high. PAY lasts exactly `bet_count` handshakes.
- The last handshake in cycle K gives `state`=CLEAR and `round_done`=1 in cycle K+1, and BET with `bet_count`=0 in cycle K+2.
- Simultaneous `wheel_done` and timeout expiry: `wheel_done` wins.
- Reset asserted in any state, including mid-PAY: the next cycle has reset values. No `round_done` or `spin_start` is emitted.

## Test plan
- Three bets with opcodes 5, 17, 40 and `chip_color`=3'b101 -> `bet_count`=3, then spin. Expect one `spin_start`, `wheel_done`, then `bet_out` sequence 8'h45, 8'h51, 8'h68 with `pay_ready` held high, `round_done` one cycle later, and `bet_count`=0.
- 13 valid bets -> the 13th gives `reject`=1 and `bet_count` stays 12. A spin then pays out exactly 12 entries.
- Bet with `chip_color`=0 -> `reject`. Spin with 0 bets -> `reject` and state stays BET. Opcode 6'b111111 -> no `reject` and no change.
- Two bets, spin, `wheel_done` never asserted with SPIN_TIMEOUT=16 -> `spin_abort` at cycle 16 of SPIN and state BET with `bet_count`=2. A second spin then pays out both entries.
- PAY with `pay_ready` toggling 0,1,0,0,1 -> `bet_out` is held during the 0 cycles and advances only on 1s. Key presses during PAY and SPIN are ignored with no `reject`.
- Reset asserted mid-PAY after one handshake -> next cycle `state`=0, `bet_count`=0, `bet_out_valid`=0, and no `round_done`.
